// File: rtl/id_stage_pipe_if.sv
// ID-stage port bundle: IF/WB/EX side inputs and the registered ID/EX bank outputs.
interface id_stage_pipe_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32
);
   logic                  iEn;
   logic                  iStall;
   logic                  iFlush;
   logic                  iValid;
   logic [PC_W-1:0]       iPC;
   logic [31:0]           iINS;
   logic                  iWbEn;
   logic [REG_ADDR_W-1:0] iWbAddr;
   logic [XLEN-1:0]       iWbData;
   logic                  iExLoad;
   logic [REG_ADDR_W-1:0] iExRd;
   logic                  oHazard;
   logic                  oValid;
   logic [PC_W-1:0]       oPC;
   logic [6:0]            oOpCode;
   logic [2:0]            oFunc3;
   logic [6:0]            oFunc7;
   logic [REG_ADDR_W-1:0] oAddrRd;
   logic [REG_ADDR_W-1:0] oAddrRs1;
   logic [REG_ADDR_W-1:0] oAddrRs2;
   logic [XLEN-1:0]       oRs1;
   logic [XLEN-1:0]       oRs2;
   logic [XLEN-1:0]       oImm;
   logic                  oMemEn;
   logic                  oWriteEn;
   logic                  oIllegal;
   logic                  oPCS_EXT;
   logic [PC_W-1:0]       oPC_EXT;

   modport master (
      output iEn, iStall, iFlush, iValid, iPC, iINS, iWbEn, iWbAddr, iWbData, iExLoad, iExRd,
      input  oHazard, oValid, oPC, oOpCode, oFunc3, oFunc7, oAddrRd, oAddrRs1, oAddrRs2,
             oRs1, oRs2, oImm, oMemEn, oWriteEn, oIllegal, oPCS_EXT, oPC_EXT
   );

   modport slave (
      input  iEn, iStall, iFlush, iValid, iPC, iINS, iWbEn, iWbAddr, iWbData, iExLoad, iExRd,
      output oHazard, oValid, oPC, oOpCode, oFunc3, oFunc7, oAddrRd, oAddrRs1, oAddrRs2,
             oRs1, oRs2, oImm, oMemEn, oWriteEn, oIllegal, oPCS_EXT, oPC_EXT
   );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32 instruction-decode stage: register file, field/immediate decode, load-use
// hazard detection, registered ID/EX bank and early JAL redirect with a
// one-instruction wrong-path squash.
// Optional macro ID_BYPASS_EN: write-back data is forwarded into the operands in the
// same cycle; without it a write-back to a used source stalls IF for one cycle instead.
module id_stage_pipe #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32
) (
   input logic              iClk,
   input logic              nRst,
   id_stage_pipe_if.slave   bus
);
   localparam int NREG = 2**REG_ADDR_W;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   typedef struct packed {
      logic                  valid;
      logic [PC_W-1:0]       pc;
      logic [6:0]            opcode;
      logic [2:0]            f3;
      logic [6:0]            f7;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [XLEN-1:0]       rs1_val;
      logic [XLEN-1:0]       rs2_val;
      logic [XLEN-1:0]       imm;
      logic                  mem_en;
      logic                  wr_en;
      logic                  illegal;
      logic                  pcs;
      logic [PC_W-1:0]       pc_ext;
   } idex_t;

   // ---------------- field decode ----------------
   logic [6:0]            opcode;
   logic [2:0]            f3;
   logic [6:0]            f7;
   logic [REG_ADDR_W-1:0] rd, rs1, rs2;
   logic                  is_r, is_i, is_s, is_b, is_u, is_j, known;
   logic                  use_rs1, use_rs2, writes_rd;
   logic [31:0]           imm_j, imm32;
   logic [XLEN-1:0]       imm;

   assign opcode = bus.iINS[6:0];
   assign rd     = REG_ADDR_W'(bus.iINS[11:7]);
   assign f3     = bus.iINS[14:12];
   assign rs1    = REG_ADDR_W'(bus.iINS[19:15]);
   assign rs2    = REG_ADDR_W'(bus.iINS[24:20]);
   assign f7     = bus.iINS[31:25];

   assign is_r  = (opcode == OP_REG);
   assign is_i  = (opcode == OP_IMM) || (opcode == OP_LOAD) || (opcode == OP_JALR);
   assign is_s  = (opcode == OP_STORE);
   assign is_b  = (opcode == OP_BRANCH);
   assign is_u  = (opcode == OP_LUI) || (opcode == OP_AUIPC);
   assign is_j  = (opcode == OP_JAL);
   assign known = is_r || is_i || is_s || is_b || is_u || is_j;

   assign use_rs1   = is_r || is_i || is_s || is_b;
   assign use_rs2   = is_r || is_s || is_b;
   assign writes_rd = (is_r || is_i || is_u || is_j) && (rd != '0);

   assign imm_j = {{11{bus.iINS[31]}}, bus.iINS[31], bus.iINS[19:12], bus.iINS[20],
                   bus.iINS[30:21], 1'b0};

   // immediate selected by instruction format, sign-extended to XLEN
   always_comb begin
      imm32 = '0;
      if (is_i)      imm32 = {{20{bus.iINS[31]}}, bus.iINS[31:20]};
      else if (is_s) imm32 = {{20{bus.iINS[31]}}, bus.iINS[31:25], bus.iINS[11:7]};
      else if (is_b) imm32 = {{19{bus.iINS[31]}}, bus.iINS[31], bus.iINS[7],
                              bus.iINS[30:25], bus.iINS[11:8], 1'b0};
      else if (is_u) imm32 = {bus.iINS[31:12], 12'b0};
      else if (is_j) imm32 = imm_j;
   end
   assign imm = XLEN'($signed(imm32));

   // ---------------- register file ----------------
   logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
   logic                      wb_we;

   assign wb_we = bus.iWbEn && (bus.iWbAddr != '0);

   // write-back port; x0 is never written so it stays zero
   always_comb begin
      rf_d = rf_q;
      if (wb_we) rf_d[bus.iWbAddr] = bus.iWbData;
   end

   // register file storage
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) rf_q <= '0;
      else       rf_q <= rf_d;
   end

   logic            wb_hit1, wb_hit2, wb_match;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign wb_hit1 = wb_we && (bus.iWbAddr == rs1);
   assign wb_hit2 = wb_we && (bus.iWbAddr == rs2);

`ifdef ID_BYPASS_EN
   // same-cycle write-back data overrides the stale array value
   assign wb_match = 1'b0;
   assign rs1_val  = wb_hit1 ? bus.iWbData : ((rs1 == '0) ? '0 : rf_q[rs1]);
   assign rs2_val  = wb_hit2 ? bus.iWbData : ((rs2 == '0) ? '0 : rf_q[rs2]);
`else
   // no forwarding: a write-back to a live source stalls IF one cycle instead
   assign wb_match = (use_rs1 && wb_hit1) || (use_rs2 && wb_hit2);
   assign rs1_val  = (rs1 == '0) ? '0 : rf_q[rs1];
   assign rs2_val  = (rs2 == '0) ? '0 : rf_q[rs2];
`endif

   // ---------------- hazard ----------------
   logic ex_match, hazard, hold;

   assign ex_match = bus.iExLoad && (bus.iExRd != '0) &&
                     ((use_rs1 && (rs1 == bus.iExRd)) || (use_rs2 && (rs2 == bus.iExRd)));
   assign hazard   = bus.iValid && (ex_match || wb_match);
   assign hold     = bus.iStall || !bus.iEn;
   assign bus.oHazard = hazard;

   // ---------------- squash FSM ----------------
   state_t state_q, state_d;
   logic   live;

   // FSM state register
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) state_q <= RUN;
      else       state_q <= state_d;
   end

   // next state: a JAL arms the squash, the next accepted instruction disarms it
   always_comb begin
      state_d = state_q;
      if (bus.iFlush)                    state_d = RUN;
      else if (!hold && !hazard) begin
         if (state_q == RUN && bus.iValid && is_j) state_d = SQUASH;
         else if (state_q == SQUASH && bus.iValid) state_d = RUN;
      end
   end

   // FSM output: only RUN lets a valid instruction through as live
   always_comb begin
      live = bus.iValid && (state_q == RUN);
   end

   // ---------------- ID/EX bank ----------------
   idex_t bank_q, bank_d;

   // bank update: flush > hold > hazard bubble > normal load; redirect is a one-cycle pulse
   always_comb begin
      bank_d     = bank_q;
      bank_d.pcs = 1'b0;
      if (bus.iFlush) begin
         bank_d.valid   = 1'b0;
         bank_d.mem_en  = 1'b0;
         bank_d.wr_en   = 1'b0;
         bank_d.illegal = 1'b0;
      end else if (!hold) begin
         bank_d.pc      = bus.iPC;
         bank_d.opcode  = opcode;
         bank_d.f3      = f3;
         bank_d.f7      = f7;
         bank_d.rd      = rd;
         bank_d.rs1     = rs1;
         bank_d.rs2     = rs2;
         bank_d.rs1_val = rs1_val;
         bank_d.rs2_val = rs2_val;
         bank_d.imm     = imm;
         bank_d.valid   = live && !hazard;
         bank_d.mem_en  = live && !hazard && ((opcode == OP_LOAD) || is_s);
         bank_d.wr_en   = live && !hazard && writes_rd;
         bank_d.illegal = live && !hazard && !known;
         if (live && !hazard && is_j) begin
            bank_d.pcs    = 1'b1;
            bank_d.pc_ext = bus.iPC + PC_W'($signed(imm_j));
         end
      end
   end

   // ID/EX register bank
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) bank_q <= '0;
      else       bank_q <= bank_d;
   end

   assign bus.oValid   = bank_q.valid;
   assign bus.oPC      = bank_q.pc;
   assign bus.oOpCode  = bank_q.opcode;
   assign bus.oFunc3   = bank_q.f3;
   assign bus.oFunc7   = bank_q.f7;
   assign bus.oAddrRd  = bank_q.rd;
   assign bus.oAddrRs1 = bank_q.rs1;
   assign bus.oAddrRs2 = bank_q.rs2;
   assign bus.oRs1     = bank_q.rs1_val;
   assign bus.oRs2     = bank_q.rs2_val;
   assign bus.oImm     = bank_q.imm;
   assign bus.oMemEn   = bank_q.mem_en;
   assign bus.oWriteEn = bank_q.wr_en;
   assign bus.oIllegal = bank_q.illegal;
   assign bus.oPCS_EXT = bank_q.pcs;
   assign bus.oPC_EXT  = bank_q.pc_ext;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expectations are queued as each step is driven
// and popped when the registered outputs are sampled after the edge.
module tb_id_stage_pipe;
   logic iClk = 1'b0;
   logic nRst = 1'b0;
   always #5 iClk = ~iClk;

   id_stage_pipe_if bus ();
   id_stage_pipe dut (.iClk(iClk), .nRst(nRst), .bus(bus));

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        wen, mem, ill, pcs;
      logic [31:0] pcext, rs1v, rs2v;
      logic        chk;
      int          id;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;

   function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] imm, input logic wen, input logic mem,
                               input logic ill, input logic pcs, input logic [31:0] pcext,
                               input logic [31:0] rs1v, input logic [31:0] rs2v,
                               input logic chk);
      exp_t e;
      e.valid = v;   e.pc = pc;     e.rd = rd;     e.imm = imm;
      e.wen = wen;   e.mem = mem;   e.ill = ill;   e.pcs = pcs;
      e.pcext = pcext; e.rs1v = rs1v; e.rs2v = rs2v; e.chk = chk; e.id = 0;
      return e;
   endfunction

   task automatic cmp(input string tag, input int id, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s step %0d observed=%h expected=%h", tag, id, obs, expv);
      end
   endtask

   task automatic check_out();
      exp_t e;
      e = q.pop_front();
      cmp("oValid",   e.id, 32'(bus.oValid),   32'(e.valid));
      cmp("oWriteEn", e.id, 32'(bus.oWriteEn), 32'(e.wen));
      cmp("oMemEn",   e.id, 32'(bus.oMemEn),   32'(e.mem));
      cmp("oIllegal", e.id, 32'(bus.oIllegal), 32'(e.ill));
      cmp("oPCS_EXT", e.id, 32'(bus.oPCS_EXT), 32'(e.pcs));
      if (e.pcs) cmp("oPC_EXT", e.id, bus.oPC_EXT, e.pcext);
      if (e.chk) begin
         cmp("oPC",     e.id, bus.oPC,           e.pc);
         cmp("oAddrRd", e.id, 32'(bus.oAddrRd),  32'(e.rd));
         cmp("oImm",    e.id, bus.oImm,          e.imm);
         cmp("oRs1",    e.id, bus.oRs1,          e.rs1v);
         cmp("oRs2",    e.id, bus.oRs2,          e.rs2v);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins);
      bus.iValid = v;
      bus.iPC    = pc;
      bus.iINS   = ins;
   endtask

   // one clock: check hazard mid-cycle, then the registered result after the edge
   task automatic tick(input exp_t e, input logic hz);
      e.id = step;
      step++;
      q.push_back(e);
      @(negedge iClk);
      cmp("oHazard", e.id, 32'(bus.oHazard), 32'(hz));
      @(posedge iClk);
      #1;
      check_out();
   endtask

   exp_t bub, zero;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bub  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      bus.iEn = 1'b1;   bus.iStall = 1'b0; bus.iFlush = 1'b0;
      bus.iWbEn = 1'b0; bus.iWbAddr = '0;  bus.iWbData = '0;
      bus.iExLoad = 1'b0; bus.iExRd = '0;
      drv(0, 0, 0);

      // reset state
      repeat (2) @(posedge iClk);
      #1;
      q.push_back(zero); check_out();
      @(negedge iClk) nRst = 1'b1;

      // get live state, then reset in the middle of a cycle
      drv(1, 32'h40, 32'h00500093);
      tick(mk(1, 32'h40, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1), 0);
      #2 nRst = 1'b0;
      #1;
      q.push_back(zero); check_out();
      @(negedge iClk) nRst = 1'b1;

      // addi x1,x0,5
      drv(1, 32'h0, 32'h00500093);
      tick(mk(1, 32'h0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1), 0);

      // write x3 while decoding add x4,x3,x3
      bus.iWbEn = 1'b1; bus.iWbAddr = 5'd3; bus.iWbData = 32'hDEADBEEF;
      drv(1, 32'h4, 32'h00318233);
`ifdef ID_BYPASS_EN
      tick(mk(1, 32'h4, 4, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1), 0);
      bus.iWbEn = 1'b0;
`else
      tick(bub, 1);
      bus.iWbEn = 1'b0;
      tick(mk(1, 32'h4, 4, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1), 0);
`endif

      // load-use on sw x2,0(x5)
      bus.iExLoad = 1'b1; bus.iExRd = 5'd2;
      drv(1, 32'h8, 32'h0022A023);
      tick(bub, 1);
      bus.iExLoad = 1'b0;
      tick(mk(1, 32'h8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), 0);

      // JAL at 0x100 +0x20, squashed follower, then live
      drv(1, 32'h100, 32'h020000EF);
      tick(mk(1, 32'h100, 1, 32'h20, 1, 0, 0, 1, 32'h120, 0, 0, 1), 0);
      drv(1, 32'h104, 32'h00700313);
      tick(bub, 0);
      drv(1, 32'h108, 32'h00900393);
      tick(mk(1, 32'h108, 7, 9, 1, 0, 0, 0, 0, 0, 0, 1), 0);

      // JAL under flush is dropped; next instruction is live (x3 read on rs2)
      bus.iFlush = 1'b1;
      drv(1, 32'h200, 32'h020000EF);
      tick(bub, 0);
      bus.iFlush = 1'b0;
      drv(1, 32'h204, 32'h00300413);
      tick(mk(1, 32'h204, 8, 3, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1), 0);

      // three stalled cycles hold the bank
      bus.iStall = 1'b1;
      drv(1, 32'h208, 32'h00318233);
      for (int i = 0; i < 3; i++)
         tick(mk(1, 32'h204, 8, 3, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1), 0);
      bus.iStall = 1'b0;
      tick(mk(1, 32'h208, 4, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1), 0);

      // redirect pulse drops under stall; stall does not consume the squash
      drv(1, 32'h300, 32'h020000EF);
      tick(mk(1, 32'h300, 1, 32'h20, 1, 0, 0, 1, 32'h320, 0, 0, 1), 0);
      bus.iStall = 1'b1;
      drv(1, 32'h304, 32'h00700313);
      tick(mk(1, 32'h300, 1, 32'h20, 1, 0, 0, 0, 0, 0, 0, 1), 0);
      bus.iStall = 1'b0;
      tick(bub, 0);
      drv(1, 32'h308, 32'h00900393);
      tick(mk(1, 32'h308, 7, 9, 1, 0, 0, 0, 0, 0, 0, 1), 0);

      // unknown opcode
      drv(1, 32'h400, 32'h0000007F);
      tick(mk(1, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), 0);

      // no valid input, then enable low holds
      drv(0, 32'h404, 32'h00500093);
      tick(bub, 0);
      drv(1, 32'h408, 32'h00500093);
      tick(mk(1, 32'h408, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1), 0);
      bus.iEn = 1'b0;
      drv(1, 32'h40C, 32'h0000007F);
      tick(mk(1, 32'h408, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1), 0);
      bus.iEn = 1'b1;

      // write-back to x0 neither hazards nor changes x0
      bus.iWbEn = 1'b1; bus.iWbAddr = 5'd0; bus.iWbData = 32'h1234;
      drv(1, 32'h500, 32'h000004B3);
      tick(mk(1, 32'h500, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1), 0);
      bus.iWbEn = 1'b0;
      drv(1, 32'h504, 32'h000004B3);
      tick(mk(1, 32'h504, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
